// File: rtl/llr_pkg.sv
// llr_pkg: shared mode encoding and saturation limit for the f/g LLR datapath
package llr_pkg;
   // Beat operation: f is the min-sum check update, g the partial-sum-driven combine
   typedef enum logic {LLR_F = 1'b0, LLR_G = 1'b1} llr_mode_e;
   // Largest magnitude kept after saturation; the range is symmetric so -max is never produced
   function automatic int sat_lim(input int w);
      return (1 << (w - 1)) - 1;
   endfunction
endpackage

// File: rtl/llr_fg_lane.sv
// llr_fg_lane: one combinational f/g lane with symmetric saturation
//   mode : LLR_F or LLR_G for this beat
//   a, b : signed W-bit LLRs
//   us   : partial-sum bit (g mode only)
//   y    : saturated signed W-bit result
//   sat  : result was clipped
module llr_fg_lane
   import llr_pkg::*;
#(
   parameter int W       = 8,
   parameter int G_HALVE = 1
) (
   input  llr_mode_e    mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         us,
   output logic [W-1:0] y,
   output logic         sat
);
   localparam logic signed [W+1:0] LIM  = (W+2)'(sat_lim(W));
   localparam logic signed [W+1:0] NLIM = -LIM;
   logic signed [W+1:0] ae, be, s, sh, h, g, me, f, r;
   logic [W:0] ma, mb, m;
   logic hi, lo;
   always_comb begin
      ae = {{2{a[W-1]}}, a};
      be = {{2{b[W-1]}}, b};
      // W+2 bits hold b +/- a for every input, including negating the most negative a
      s  = be + (us ? -ae : ae);
      sh = s >>> 1;
      // floor shift already rounds odd negatives away from zero; odd positives need +1
      h  = sh + {{(W+1){1'b0}}, ~s[W+1] & s[0]};
      g  = (G_HALVE != 0) ? h : s;
      // W+1 bit magnitudes so |-2^(W-1)| is representable
      ma = a[W-1] ? -{a[W-1], a} : {a[W-1], a};
      mb = b[W-1] ? -{b[W-1], b} : {b[W-1], b};
      m  = (ma < mb) ? ma : mb;
      me = {1'b0, m};
      f  = (a[W-1] ^ b[W-1]) ? -me : me;
      r  = (mode == LLR_G) ? g : f;
      hi = r > LIM;
      lo = r < NLIM;
      y  = hi ? LIM[W-1:0] : lo ? NLIM[W-1:0] : r[W-1:0];
      sat = hi | lo;
   end
endmodule

// File: rtl/llr_fg_array.sv
// llr_fg_array: LANES-wide f/g LLR unit, 2-stage valid/ready pipeline with frame tracking
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : input handshake
//   in_mode                     : 0=f, 1=g, taken from the first beat of each frame
//   in_a, in_b, in_us, in_last  : lane-packed LLRs, partial sums, end-of-frame marker
//   out_valid/out_ready         : output handshake
//   out_llr, out_sat, out_last  : lane-packed results, per-lane clip flags, end-of-frame marker
//   frame_err, err_clr          : sticky framing error and its clear
module llr_fg_array
   import llr_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int LANES       = 4,
   parameter int FRAME_BEATS = 8,
   parameter int G_HALVE     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_mode,
   input  logic [LANES*DATA_WIDTH-1:0] in_a,
   input  logic [LANES*DATA_WIDTH-1:0] in_b,
   input  logic [LANES-1:0]            in_us,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_llr,
   output logic [LANES-1:0]            out_sat,
   output logic                        out_last,
   output logic                        frame_err,
   input  logic                        err_clr
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BEATS - 1);

   logic                 s1_valid;
   llr_mode_e            s1_mode;
   logic [LANES*W-1:0]   s1_a, s1_b;
   logic [LANES-1:0]     s1_us;
   logic                 s1_last;
   logic [CW-1:0]        cnt;
   llr_mode_e            mode_q;
   logic [LANES*W-1:0]   lane_llr;
   logic [LANES-1:0]     lane_sat;
   logic                 s2_adv, accept, at_end, bad;
   llr_mode_e            beat_mode;

   // the output register moves whenever it is empty or being drained
   assign s2_adv    = !out_valid || out_ready;
   assign in_ready  = !s1_valid || s2_adv;
   assign accept    = in_valid && in_ready;
   assign at_end    = cnt == CNT_LAST;
   // first beat of a frame supplies the mode; later beats reuse the latched one
   assign beat_mode = (cnt == '0) ? llr_mode_e'(in_mode) : mode_q;
   assign bad       = accept && (in_last != at_end);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      llr_fg_lane #(.W(W), .G_HALVE(G_HALVE)) u_lane (
         .mode (s1_mode),
         .a    (s1_a[i*W +: W]),
         .b    (s1_b[i*W +: W]),
         .us   (s1_us[i]),
         .y    (lane_llr[i*W +: W]),
         .sat  (lane_sat[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_mode   <= LLR_F;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_us     <= '0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_llr   <= '0;
         out_sat   <= '0;
         out_last  <= 1'b0;
         cnt       <= '0;
         mode_q    <= LLR_F;
         frame_err <= 1'b0;
      end else begin
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_llr  <= lane_llr;
               out_sat  <= lane_sat;
               out_last <= s1_last;
            end
         end
         if (in_ready) s1_valid <= in_valid;
         if (accept) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_us   <= in_us;
            s1_last <= in_last;
            s1_mode <= beat_mode;
            mode_q  <= beat_mode;
            cnt     <= (in_last || at_end) ? '0 : cnt + 1'b1;
         end
         // a new error in the same cycle as err_clr keeps the flag set
         frame_err <= bad ? 1'b1 : err_clr ? 1'b0 : frame_err;
      end
   end
endmodule

// File: tb/tb_llr_fg_array.sv
// tb_llr_fg_array: directed and randomized checks of llr_fg_array against an integer reference model
module tb_llr_fg_array;
   localparam int W   = 8;
   localparam int L   = 4;
   localparam int FB  = 8;
   localparam int GH  = 1;
   localparam int LIM = 2 ** (W - 1) - 1;

   typedef struct {
      logic [L*W-1:0] llr;
      logic [L-1:0]   sat;
      logic           last;
   } exp_t;

   logic clk = 1'b0, rst = 1'b0;
   logic in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
   logic [L*W-1:0] in_a = '0, in_b = '0;
   logic [L-1:0] in_us = '0;
   logic in_ready, out_valid, out_last, frame_err;
   logic [L*W-1:0] out_llr;
   logic [L-1:0] out_sat;

   int total = 0, bad = 0;
   exp_t q[$];
   exp_t me;
   int p = 0;
   bit fm = 1'b0;
   logic exp_err = 1'b0;
   bit hold = 1'b0, rnd_ready = 1'b0, held = 1'b0;
   logic [L*W-1:0] h_llr;
   logic [L-1:0] h_sat;
   logic h_last;

   llr_fg_array #(.DATA_WIDTH(W), .LANES(L), .FRAME_BEATS(FB), .G_HALVE(GH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_a(in_a), .in_b(in_b), .in_us(in_us), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_llr(out_llr), .out_sat(out_sat),
      .out_last(out_last), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      out_ready = hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ref_lane(input bit g, input int a, input int b, input bit us);
      int t, ma, mb, m;
      if (g) begin
         t = b + (us ? -a : a);
         if (GH != 0) t = (t % 2 == 0) ? t / 2 : (t > 0 ? (t + 1) / 2 : (t - 1) / 2);
      end else begin
         ma = (a < 0) ? -a : a;
         mb = (b < 0) ? -b : b;
         m = (ma < mb) ? ma : mb;
         t = ((a < 0) != (b < 0)) ? -m : m;
      end
      return t;
   endfunction

   task automatic model_accept(input bit md, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                               input logic [L-1:0] us, input bit last);
      exp_t e;
      int r;
      bit berr;
      if (p == 0) fm = md;
      for (int i = 0; i < L; i++) begin
         r = ref_lane(fm, int'($signed(a[i*W +: W])), int'($signed(b[i*W +: W])), us[i]);
         e.sat[i] = (r > LIM) || (r < -LIM);
         r = (r > LIM) ? LIM : (r < -LIM) ? -LIM : r;
         e.llr[i*W +: W] = r[W-1:0];
      end
      e.last = last;
      q.push_back(e);
      berr = last != (p == FB - 1);
      exp_err = berr ? 1'b1 : (err_clr ? 1'b0 : exp_err);
      p = (last || p == FB - 1) ? 0 : p + 1;
   endtask

   task automatic send(input bit md, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                       input logic [L-1:0] us, input bit last);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_mode = md; in_a = a; in_b = b; in_us = us; in_last = last;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", 64'(in_ready), 64'(1));
      model_accept(md, a, b, us, last);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rv();
      int k = $urandom_range(0, 5);
      logic [W-1:0] mn = '0;
      mn[W-1] = 1'b1;
      return (k == 0) ? mn : (k == 1) ? ~mn : (k == 2) ? mn + 1'b1 : W'($urandom);
   endfunction

   function automatic logic [L*W-1:0] rvec();
      logic [L*W-1:0] v;
      for (int i = 0; i < L; i++) v[i*W +: W] = rv();
      return v;
   endfunction

   task automatic rand_beats(input bit md, input int n, input int last_at);
      for (int k = 0; k < n; k++)
         send((k == 0) ? md : bit'($urandom_range(0, 1)), rvec(), rvec(), L'($urandom), k == last_at);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(q.size()), 64'(0));
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      exp_err = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst || !out_valid) held = 1'b0;
      else begin
         if (held) begin
            chk("hold_llr", 64'(out_llr), 64'(h_llr));
            chk("hold_sat", 64'(out_sat), 64'(h_sat));
            chk("hold_last", 64'(out_last), 64'(h_last));
         end
         if (out_ready) begin
            if (q.size() == 0) chk("unexpected_beat", 64'(out_valid), 64'(0));
            else begin
               me = q.pop_front();
               chk("llr", 64'(out_llr), 64'(me.llr));
               chk("sat", 64'(out_sat), 64'(me.sat));
               chk("last", 64'(out_last), 64'(me.last));
            end
            held = 1'b0;
         end else begin
            held = 1'b1;
            h_llr = out_llr;
            h_sat = out_sat;
            h_last = out_last;
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_frame_err", 64'(frame_err), 64'(0));
      chk("rst_out_llr", 64'(out_llr), 64'(0));
      chk("rst_out_sat", 64'(out_sat), 64'(0));
      rst = 1'b0;

      // g mode directed lanes: (5,4,us0), (5,4,us1), (-128,127,us1), (-1,2,us0)
      send(1'b1, {8'hff, 8'h80, 8'd5, 8'd5}, {8'd2, 8'd127, 8'd4, 8'd4}, 4'b0110, 1'b0);
      rand_beats(1'b1, 7, 6);
      drain();
      chk("g_frame_err", 64'(frame_err), 64'(exp_err));

      // f mode directed lanes: (-7,3), (-128,-128), (0,-5), (127,-128)
      send(1'b0, {8'h7f, 8'h00, 8'h80, 8'hf9}, {8'h80, 8'hfb, 8'h80, 8'h03}, 4'b1111, 1'b0);
      rand_beats(1'b0, 7, 6);
      drain();

      // backpressure: two beats fill both stages, then in_ready must drop
      hold = 1'b1;
      rand_beats(1'b1, 2, -1);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      hold = 1'b0;
      rand_beats(1'b0, 4, -1);
      rand_beats(1'b0, 2, 1);
      drain();
      chk("bp_frame_err", 64'(frame_err), 64'(exp_err));

      // early last on beat 5 of 8, then a new frame in the other mode
      rand_beats(1'b1, 5, 4);
      chk("early_last_err", 64'(frame_err), 64'(exp_err));
      rand_beats(1'b0, 8, 7);
      drain();
      chk("err_sticky", 64'(frame_err), 64'(exp_err));
      clear_err();
      chk("err_cleared", 64'(frame_err), 64'(exp_err));

      // err_clr coincident with a new error: the error is kept
      err_clr = 1'b1;
      send(1'b1, rvec(), rvec(), 4'b1010, 1'b1);
      err_clr = 1'b0;
      chk("set_wins", 64'(frame_err), 64'(exp_err));
      drain();

      // reset with both stages holding beats mid-frame
      hold = 1'b1;
      rand_beats(1'b0, 2, -1);
      chk("err_before_rst", 64'(frame_err), 64'(exp_err));
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_frame_err", 64'(frame_err), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      q.delete();
      p = 0;
      exp_err = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rand_beats(1'b1, 8, 7);
      drain();
      chk("post_rst_err", 64'(frame_err), 64'(exp_err));

      // randomized frames with random backpressure and occasional early ends
      rnd_ready = 1'b1;
      for (int f = 0; f < 12; f++) begin
         int n = $urandom_range(1, FB);
         rand_beats(bit'($urandom_range(0, 1)), n, ($urandom_range(0, 2) != 0) ? n - 1 : -1);
         chk("rnd_frame_err", 64'(frame_err), 64'(exp_err));
         if (exp_err) clear_err();
      end
      rnd_ready = 1'b0;
      drain();
      chk("final_err", 64'(frame_err), 64'(exp_err));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/llr_fg_array.md
LLR_FG_ARRAY -- requirements
Module: llr_fg_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the signed LLR width W (minimum 4).
REQ-002 SHALL have parameter LANES, default 4, meaning the number of parallel f/g lanes per beat.
REQ-003 SHALL have parameter FRAME_BEATS, default 8, meaning the number of beats per frame (minimum 1).
REQ-004 SHALL have parameter G_HALVE, default 1, meaning g output is halved when 1 and is the full sum when 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the beat.
REQ-009 SHALL have port in_mode, input, 1 bit: 0 selects f, 1 selects g; sampled on the first beat of a frame only.
REQ-010 SHALL have ports in_a and in_b, input, LANES*W bits each: signed LLRs; lane i occupies bits [i*W +: W].
REQ-011 SHALL have port in_us, input, LANES bits: partial-sum bit per lane, used in g mode only.
REQ-012 SHALL have port in_last, input, 1 bit: last beat of the frame.
REQ-013 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output handshake.
REQ-014 SHALL have port out_llr, output, LANES*W bits: signed results, using the same lane packing as in_a.
REQ-015 SHALL have port out_sat, output, LANES bits: per-lane saturation flag for the beat.
REQ-016 SHALL have port out_last, output, 1 bit: in_last propagated with the beat.
REQ-017 SHALL have port frame_err, output, 1 bit (sticky), and port err_clr, input, 1 bit: framing error flag and its clear.

Function
REQ-018 SHALL transfer a beat only when valid and ready are both high on the same rising edge.
REQ-019 SHALL use a 2-stage pipeline: latency 2 cycles from acceptance to out_valid; throughput 1 beat per cycle while out_ready is high.
REQ-020 SHALL advance each stage when that stage is empty or the downstream stage advances; in_ready = !s1_valid || s1_advance; no combinational path from out_ready to in_ready other than this.
REQ-021 SHALL hold out_llr, out_sat and out_last stable while out_valid is high and out_ready is low; no beat is lost, duplicated or reordered.
REQ-022 SHALL compute g mode as s = b + (us ? -a : a) at W+2 bits with no overflow; negating -2^(W-1) is exact.
REQ-023 When G_HALVE=1, SHALL output s>>>1 in g mode, plus 1 when s>0 and s is odd (round half away from zero); when G_HALVE=0 the output is s.
REQ-024 SHALL compute f mode as sign(a) XOR sign(b) applied to min(|a|,|b|), with magnitudes computed at W+1 bits.
REQ-025 SHALL saturate results to [-(2^(W-1)-1), 2^(W-1)-1] (symmetric) and set the lane's out_sat when clipping occurs.
REQ-026 SHALL keep a beat counter 0..FRAME_BEATS-1 that advances on each accepted beat.
REQ-027 SHALL latch in_mode when the counter is 0; that mode applies to every beat of the frame, and each beat carries its mode through the pipeline.
REQ-028 SHALL return the counter to 0 after accepting a beat with in_last=1 or with counter=FRAME_BEATS-1, whichever comes first.
REQ-029 SHALL set frame_err when in_last disagrees with (counter==FRAME_BEATS-1) on an accepted beat.
REQ-030 SHALL clear frame_err on err_clr; if err_clr and a new error occur in the same cycle, the set wins.

Reset
REQ-031 SHALL, on rst, clear out_valid, both stage-valid bits, out_llr, out_sat, out_last, the beat counter, the latched mode and frame_err immediately; in_ready is 1 after reset.
REQ-032 SHALL discard beats in flight when rst is asserted mid-frame; the next accepted beat starts a new frame.

Structure
REQ-033 SHALL place the mode encoding (LLR_F, LLR_G) and the saturation-limit function in a shared package llr_pkg.
REQ-034 SHALL implement the per-lane arithmetic as the combinational sub-module llr_fg_lane, instantiated LANES times with generate.

Verification (W=8, LANES=4, FRAME_BEATS=8, G_HALVE=1)
REQ-035 g mode: us=0, a=5, b=4 -> out 5; us=1, a=5, b=4 -> out -1; out_sat=0 in both cases.
REQ-036 g mode: us=1, a=-128, b=127 -> s=255 halves to 128 -> out 127 with out_sat=1.
REQ-037 f mode: a=-7, b=3 -> out -3; a=-128, b=-128 -> out 127 with out_sat=1.
REQ-038 Stream 6 beats with out_ready low for 3 cycles -> in_ready drops once 2 beats are held; all 6 beats emerge in order and unchanged.
REQ-039 Assert in_last on beat 5 of 8 -> frame_err=1 and the next beat starts at counter 0; err_clr -> frame_err=0.
REQ-040 Assert rst mid-frame with the pipeline full -> out_valid=0 in the same cycle and frame_err=0; the next frame latches a new mode.
